// File: rtl/ysyx_24070016_pkg.sv
// Shared types and defaults for the ysyx_24070016 write-back path.
// Holds the WBU state encoding and the pipeline-register entry layout.
package ysyx_24070016_pkg;

  localparam int XLEN_D   = 32;
  localparam int NR_REG_D = 32;
  localparam int AW_D     = $clog2(NR_REG_D);
  localparam int REG_A0   = 10;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    HALT
  } wbu_state_e;

  typedef struct packed {
    logic [XLEN_D-1:0] result;
    logic [AW_D-1:0]   rd;
    logic              wen;
    logic              ebreak;
  } wb_entry_t;

endpackage

// File: rtl/ysyx_24070016_gpr.sv
// Architectural GPR file: one write port, two combinational read ports.
// x0 and out-of-range addresses read as zero and ignore writes.
module ysyx_24070016_gpr
  import ysyx_24070016_pkg::*;
#(
  parameter int XLEN   = XLEN_D,
  parameter int NR_REG = NR_REG_D,
  parameter int AW     = $clog2(NR_REG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic [XLEN-1:0] a0
);

  logic [XLEN-1:0] regs [NR_REG];

  function automatic logic live(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < 32'(NR_REG));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_REG; i++)
        regs[i] <= '0;
    end else if (wen && live(waddr)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = live(raddr1) ? regs[raddr1] : '0;
  assign rdata2 = live(raddr2) ? regs[raddr2] : '0;
  assign a0     = regs[AW'(REG_A0)];

endmodule

// File: rtl/ysyx_24070016_wbu.sv
// Write-back stage: one-entry pipeline register, GPR commit, ebreak halt.
// Define YSYX_24070016_WBU_BYPASS_EN to forward the pending result to reads.
module ysyx_24070016_wbu
  import ysyx_24070016_pkg::*;
#(
  parameter  int XLEN     = XLEN_D,
  parameter  int NR_REG   = NR_REG_D,
  parameter  int RETIRE_W = 64,
  localparam int AW       = $clog2(NR_REG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_result,
  input  logic [AW-1:0]       in_rd,
  input  logic                in_wen,
  input  logic                in_ebreak,
  input  logic [AW-1:0]       rs1_addr,
  input  logic [AW-1:0]       rs2_addr,
  output logic [XLEN-1:0]     rs1_data,
  output logic [XLEN-1:0]     rs2_data,
  output logic                pend_valid,
  output logic [AW-1:0]       pend_rd,
  output logic                halted,
  output logic [XLEN-1:0]     halt_code,
  output logic [RETIRE_W-1:0] retire_cnt
);

  wbu_state_e      state, state_nxt;
  wb_entry_t       pend;
  logic            accept, commit, halt_now;
  logic [AW-1:0]   prd;
  logic [XLEN-1:0] pres, gpr1, gpr2, a0_cur;

  assign prd  = AW'(pend.rd);
  assign pres = XLEN'(pend.result);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = accept ? PEND : IDLE;
      PEND: begin
        if (pend.ebreak) state_nxt = HALT;
        else             state_nxt = accept ? PEND : IDLE;
      end
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // a pending ebreak blocks the same-edge accept
  always_comb begin
    in_ready = !rst && (state != HALT)
             && !((state == PEND) && pend.ebreak);
    accept   = in_valid && in_ready;
    commit   = !rst && (state == PEND);
    halt_now = commit && pend.ebreak;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= '0;
      halted     <= 1'b0;
      halt_code  <= '0;
      retire_cnt <= '0;
    end else begin
      if (accept) begin
        pend.result <= XLEN_D'(in_result);
        pend.rd     <= AW_D'(in_rd);
        pend.wen    <= in_wen;
        pend.ebreak <= in_ebreak;
      end
      if (commit)
        retire_cnt <= retire_cnt + RETIRE_W'(1);
      if (halt_now) begin
        halted    <= 1'b1;
        halt_code <= (pend.wen && prd == AW'(REG_A0))
                   ? pres : a0_cur;
      end
    end
  end

  ysyx_24070016_gpr #(
    .XLEN   (XLEN),
    .NR_REG (NR_REG),
    .AW     (AW)
  ) u_gpr (
    .clk    (clk),
    .rst    (rst),
    .wen    (commit && pend.wen),
    .waddr  (prd),
    .wdata  (pres),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (gpr1),
    .rdata2 (gpr2),
    .a0     (a0_cur)
  );

  assign pend_valid = (state == PEND);
  assign pend_rd    = (pend_valid && pend.wen) ? prd : '0;

`ifdef YSYX_24070016_WBU_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok   = pend_valid && pend.wen && (prd != '0);
  assign rs1_data = (fwd_ok && rs1_addr == prd) ? pres : gpr1;
  assign rs2_data = (fwd_ok && rs2_addr == prd) ? pres : gpr2;
`else
  assign rs1_data = gpr1;
  assign rs2_data = gpr2;
`endif

endmodule

// File: doc/ysyx_24070016_wbu.md
Name: ysyx_24070016_wbu

Overview:
- Write-back stage directly downstream of the execute stage.
- Accepts the execute result plus destination/control through a valid/ready handshake and holds it for one cycle in a pipeline register.
- Commits the held result to the architectural GPR file and serves two combinational read ports to decode.
- Owns ebreak halt sequencing: latches the exit code from a0 and stops accepting work.

Parameters:
- XLEN, 32, datapath width.
- NR_REG, 32, number of GPRs (16 for RV32E); address width is clog2(NR_REG).
- RETIRE_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, single domain.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  execute stage presents a result.
- in_ready  out  1  WBU can accept.
- in_result  in  XLEN  wrback_result from the execute stage.
- in_rd  in  clog2(NR_REG)  destination register.
- in_wen  in  1  instruction writes rd.
- in_ebreak  in  1  instruction is ebreak.
- rs1_addr, rs2_addr  in  clog2(NR_REG)  decode read addresses.
- rs1_data, rs2_data  out  XLEN  read data, combinational.
- pend_valid  out  1  pipeline register holds an uncommitted entry.
- pend_rd  out  clog2(NR_REG)  rd of pending entry; 0 when the entry does not write.
- halted  out  1  ebreak committed.
- halt_code  out  XLEN  value of a0 (x10) at ebreak commit.
- retire_cnt  out  RETIRE_W  committed instruction count.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): all GPRs=0, pend_valid=0, pend_rd=0, halted=0, halt_code=0, retire_cnt=0, state=IDLE. in_ready=0 while rst is high.
- States:
  - IDLE: nothing pending.
  - PEND: entry held.
  - HALT: terminal.
- Accept: in_valid && in_ready at an edge captures result, rd, wen, ebreak into the pipeline register and moves to PEND.
- Commit: every cycle in PEND the entry commits at the next edge; latency is accept edge +1.
- Commit effects:
  - If wen and rd!=0, GPR[rd] <= result.
  - retire_cnt += 1, wrapping modulo 2^RETIRE_W.
- in_ready = (state != HALT) && !rst. Accept and commit may occur in the same edge, giving back-to-back throughput of 1/cycle. Next state is PEND if accepted, else IDLE.
- Ebreak commit:
  - Performs the normal write.
  - halt_code <= a0 value after this commit's write; if rd==10 with wen, the new result is used.
  - halted <= 1, state <= HALT, in_ready=0 from the following cycle.
  - The same-edge accept is suppressed: in_ready is forced 0 while the pending entry is ebreak.
- HALT is left only by rst.
- x0: writes are dropped and reads return 0 regardless of array content or bypass.
- Reads: rsN_data = GPR[rsN_addr], plus bypass (see feature).
- Out-of-range addresses (>= NR_REG, RV32E): reads return 0 and writes are dropped.
- Reset mid-PEND: the entry is discarded and not committed; retire_cnt stays 0.

Optional Feature:
- Macro: YSYX_24070016_WBU_BYPASS_EN.
- Defined: when pend_valid, the pending entry's wen is set, pend_rd!=0 and rsN_addr==pend_rd, rsN_data returns the pending result (forwarding).
- Undefined: reads return array content only. Decode must stall on rsN_addr==pend_rd using pend_valid/pend_rd.
- pend_valid/pend_rd are present in both builds.

Decomposition:
- Shared package ysyx_24070016_pkg:
  - XLEN and NR_REG defaults.
  - REG_A0=10.
  - wbu state enum {IDLE, PEND, HALT}.
  - The wb_entry struct {result, rd, wen, ebreak}.
- One sub-module: ysyx_24070016_gpr, holding the register array with one write port, two read ports and x0/out-of-range masking. The WBU owns the handshake, FSM, counters and bypass.

Test Plan:
- Reset then accept {result=0xDEADBEEF, rd=5, wen=1}: pend_valid=1, pend_rd=5 next cycle. Following cycle GPR[5]=0xDEADBEEF, retire_cnt=1; rs1_addr=5 reads 0xDEADBEEF.
- Write to x0 with result=0x1234: rs1_addr=0 reads 0, retire_cnt increments.
- Back-to-back accepts writing x1=1, x1=2, x1=3 on consecutive cycles: in_ready stays 1, final x1=3, retire_cnt=3.
- With BYPASS_EN, accept x7=0x55 and read rs2_addr=7 while pending: returns 0x55. Without the macro it returns old value 0 and pend_rd=7.
- Ebreak with {rd=10, wen=1, result=0x0}: halted=1, halt_code=0, in_ready=0. Further in_valid is ignored and retire_cnt frozen. Then rst=1 for one edge: halted=0, in_ready=1.
- Assert rst while an entry for x3=0x99 is pending: GPR[3] stays 0, retire_cnt=0.
